// File: rtl/tt_io_pkg.sv
// Shared constants for the Tiny Tapeout debounce/counter block: output view modes
// and bit positions of the control fields carried on uio_in.
package tt_io_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_PASS   = 2'd0;
  localparam mode_t MODE_PULSE  = 2'd1;
  localparam mode_t MODE_COUNT  = 2'd2;
  localparam mode_t MODE_TOGGLE = 2'd3;

  localparam int CTL_MODE_LSB = 0;
  localparam int CTL_SEL_LSB  = 2;
  localparam int CTL_CLR      = 7;

endpackage

// File: rtl/tt_io_debounce_ch.sv
// One input channel: synchroniser chain, debounce counter, accepted stable level
// and a one-cycle strobe when the stable level rises.
module tt_io_debounce_ch #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          db_cnt_q, db_cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], din};
    db_cnt_d = db_cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    if (ena) begin
      if (sync_out == level_q) begin
        db_cnt_d = '0;
      end else if (db_cnt_q == CNT_LAST) begin
        // The cycle that would reach DEBOUNCE_CYCLES accepts the new level directly.
        level_d  = ~level_q;
        db_cnt_d = '0;
        rise_d   = ~level_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      db_cnt_q <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      db_cnt_q <= db_cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/tt_um_io_debounce_counter.sv
// Tiny Tapeout user top: debounced input channels with a uio-selected output view
// (level, rise pulses, per-channel event count, or toggle latches).
module tt_um_io_debounce_counter
  import tt_io_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Keeps only the select bits that can address a channel; zero bits when WIDTH=1.
  localparam logic [2:0] SEL_MASK = 3'((1 << $clog2(WIDTH)) - 1);

  logic [7:0]       ctl_meta_q, ctl_meta_d;
  logic [7:0]       ctl_q, ctl_d;
  logic [WIDTH-1:0] level, rise;
  logic [WIDTH-1:0] tog_q, tog_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [7:0]       uo_q, uo_d;
  mode_t            mode;
  logic [2:0]       sel;
  logic             clr;
  logic [CNT_W-1:0] cnt_view;
  logic             unused_ctl;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    tt_io_debounce_ch #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst_n(rst_n),
      .ena  (ena),
      .din  (ui_in[g]),
      .level(level[g]),
      .rise (rise[g])
    );
  end

  assign mode       = ctl_q[CTL_MODE_LSB +: 2];
  assign sel        = ctl_q[CTL_SEL_LSB +: 3] & SEL_MASK;
  assign clr        = ctl_q[CTL_CLR];
  assign unused_ctl = &{1'b0, ctl_q[6:5]};

  always_comb begin
    ctl_meta_d = uio_in;
    ctl_d      = ctl_meta_q;
    tog_d      = tog_q;
    cnt_d      = cnt_q;
    uo_d       = uo_q;
    cnt_view   = '0;
    if (ena) begin
      tog_d = tog_q ^ rise;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = clr ? '0 : cnt_q[i] + CNT_W'(rise[i]);
      end
    end
    // Count and toggle views show next-state so every view shares the same latency.
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == 3'(i)) cnt_view = cnt_d[i];
    end
    if (ena) begin
      uo_d = '0;
      case (mode)
        MODE_PASS:  uo_d[WIDTH-1:0] = level;
        MODE_PULSE: uo_d[WIDTH-1:0] = rise;
        MODE_COUNT: uo_d[CNT_W-1:0] = cnt_view;
        default:    uo_d[WIDTH-1:0] = tog_d;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ctl_meta_q <= '0;
      ctl_q      <= '0;
      tog_q      <= '0;
      cnt_q      <= '{default: '0};
      uo_q       <= '0;
    end else begin
      ctl_meta_q <= ctl_meta_d;
      ctl_q      <= ctl_d;
      tog_q      <= tog_d;
      cnt_q      <= cnt_d;
      uo_q       <= uo_d;
    end
  end

  assign uo_out  = uo_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_io_debounce_counter.sv
// Directed bench for tt_um_io_debounce_counter: expected uo_out values are queued
// against absolute cycle numbers and checked when that cycle's edge has passed.
module tb_tt_um_io_debounce_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_io_debounce_counter dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  typedef struct {
    int         cyc;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   k;

  // Queue the value uo_out must hold after edges a..b.
  task automatic expect_range(input int a, input int b, input logic [7:0] v, input string tag);
    for (int c = a; c <= b; c++) begin
      exp_t e;
      e.cyc = c;
      e.val = v;
      e.tag = tag;
      sb.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        tests++;
        assert (uo_out === sb[i].val) else begin
          fails++;
          $error("FAIL %s cyc=%0d: uo_out=%h expected %h", sb[i].tag, cyc, uo_out, sb[i].val);
        end
        sb.delete(i);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    run(2);
    expect_range(cyc + 1, cyc + 1, 8'h00, "reset");
    run(1);
    tests++;
    assert (uio_out === 8'h00 && uio_oe === 8'h00) else begin
      fails++;
      $error("FAIL uio_tie: uio_out=%h uio_oe=%h expected 00 00", uio_out, uio_oe);
    end
    rst_n = 1'b1;
    run(4);

    // Latency of a held change in PASS mode
    k = cyc;
    expect_range(k + 1, k + 6, 8'h00, "t1_latency");
    expect_range(k + 7, k + 7, 8'h05, "t1_level");
    ui_in = 8'h05;
    run(9);

    k = cyc;
    expect_range(k + 1, k + 6, 8'h05, "t2_hold");
    expect_range(k + 7, k + 7, 8'h00, "t2_release");
    ui_in = 8'h00;
    run(10);

    // 3-cycle glitch is rejected, 4-cycle pulse is accepted
    k = cyc;
    expect_range(k + 1, k + 12, 8'h00, "t2_glitch3");
    ui_in = 8'h01;
    run(3);
    ui_in = 8'h00;
    run(12);

    k = cyc;
    expect_range(k + 1, k + 6, 8'h00, "t2_pre4");
    expect_range(k + 7, k + 10, 8'h01, "t2_pulse4");
    expect_range(k + 11, k + 13, 8'h00, "t2_post4");
    ui_in = 8'h01;
    run(4);
    ui_in = 8'h00;
    run(12);

    // PULSE mode: one strobe per rise, nothing on fall
    uio_in = 8'h01;
    run(5);
    k = cyc;
    expect_range(k + 1, k + 6, 8'h00, "t3_pre");
    expect_range(k + 7, k + 7, 8'h08, "t3_strobe");
    expect_range(k + 8, k + 10, 8'h00, "t3_post");
    ui_in = 8'h08;
    run(10);
    expect_range(cyc + 1, cyc + 10, 8'h00, "t3_fall");
    ui_in = 8'h00;
    run(10);

    // COUNT mode on channel 2 (one rise so far from the 0x05 pattern)
    k = cyc;
    expect_range(k + 1, k + 2, 8'h00, "t4_mode_old");
    expect_range(k + 3, k + 3, 8'h01, "t4_mode_new");
    uio_in = 8'h0A;
    run(5);

    k = cyc;
    expect_range(k + 1, k + 2, 8'h01, "t4_preclr");
    expect_range(k + 3, k + 3, 8'h00, "t4_clr");
    uio_in = 8'h8A;
    run(2);
    uio_in = 8'h0A;
    run(4);

    for (int p = 0; p < 300; p++) begin
      ui_in = 8'h04;
      run(5);
      ui_in = 8'h00;
      run(5);
    end
    run(10);
    expect_range(cyc + 1, cyc + 1, 8'(300 % 256), "t4_wrap");
    run(1);

    k = cyc;
    expect_range(k + 1, k + 2, 8'd44, "t4_clr_lat");
    expect_range(k + 3, k + 3, 8'h00, "t4_clr44");
    uio_in = 8'h8A;
    run(1);
    uio_in = 8'h0A;
    run(5);

    // Clear synchronised onto the very edge that consumes a rise strobe
    k = cyc;
    expect_range(k + 1, k + 10, 8'h00, "t4_clr_rise");
    ui_in = 8'h04;
    run(4);
    uio_in = 8'h8A;
    run(1);
    uio_in = 8'h0A;
    run(6);
    expect_range(cyc + 1, cyc + 10, 8'h00, "t4_clr_fall");
    ui_in = 8'h00;
    run(10);

    k = cyc;
    expect_range(k + 1, k + 6, 8'h00, "t4_after_pre");
    expect_range(k + 7, k + 7, 8'h01, "t4_after");
    ui_in = 8'h04;
    run(5);
    ui_in = 8'h00;
    run(10);

    // Reset mid-stream with channel 2 held high through it
    k = cyc;
    expect_range(k + 1, k + 6, 8'h01, "t6_pre");
    expect_range(k + 7, k + 7, 8'h02, "t6_cnt2");
    ui_in = 8'h04;
    run(10);
    k = cyc;
    expect_range(k + 1, k + 7, 8'h00, "t6_rst");
    expect_range(k + 8, k + 8, 8'h01, "t6_held_rise");
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(9);
    expect_range(cyc + 1, cyc + 10, 8'h01, "t6_fall");
    ui_in = 8'h00;
    run(10);

    // Freeze mid-debounce with ena=0, toggle the input, then resume from held count
    k = cyc;
    expect_range(k + 1, k + 26, 8'h01, "t6_freeze");
    expect_range(k + 27, k + 27, 8'h02, "t6_resume");
    ui_in = 8'h04;
    run(4);
    ena = 1'b0;
    for (int t = 0; t < 4; t++) begin
      ui_in = 8'h00;
      run(2);
      ui_in = 8'h04;
      run(2);
    end
    run(4);
    ena = 1'b1;
    run(6);
    expect_range(cyc + 1, cyc + 10, 8'h02, "t6_hold2");
    ui_in = 8'h00;
    run(10);

    // TOGGLE mode; only channel 2 has risen twice since reset, so toggles are 0
    k = cyc;
    expect_range(k + 1, k + 2, 8'h02, "t5_mode_old");
    expect_range(k + 3, k + 3, 8'h00, "t5_mode_new");
    uio_in = 8'h03;
    run(5);

    k = cyc;
    expect_range(k + 1, k + 6, 8'h00, "t5_pre");
    expect_range(k + 7, k + 18, 8'h80, "t5_tog1");
    expect_range(k + 19, k + 24, 8'h00, "t5_tog2");
    ui_in = 8'h80;
    run(6);
    ui_in = 8'h00;
    run(6);
    ui_in = 8'h80;
    run(6);
    ui_in = 8'h00;
    run(6);
    run(4);

    // Switch to COUNT sel=7 while a third rise on channel 7 is in flight
    k = cyc;
    expect_range(k + 1, k + 4, 8'h00, "t5_sw_tog");
    expect_range(k + 5, k + 6, 8'h02, "t5_sw_cnt2");
    expect_range(k + 7, k + 7, 8'h03, "t5_sw_cnt3");
    ui_in = 8'h80;
    run(2);
    uio_in = 8'h1E;
    run(4);
    ui_in = 8'h00;
    run(8);

    run(3);
    while (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s: cycle %0d never checked, expected %h", sb[0].tag, sb[0].cyc, sb[0].val);
      sb.pop_front();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
